// File: rtl/nco_phase_accu_mc_if.sv
// Bus bundle for the multi-channel NCO phase accumulator: step/sync strobes,
// channel config writes and the per-channel LUT index outputs.
interface nco_phase_accu_mc_if #(
  parameter int ACC_W  = 32,
  parameter int IDX_W  = 10,
  parameter int NUM_CH = 4,
  parameter int CH_W   = 4
);
  logic                    valid_i;
  logic                    sync_i;
  logic                    cfg_we_i;
  logic                    cfg_sel_i;
  logic [CH_W-1:0]         cfg_ch_i;
  logic [ACC_W-1:0]        cfg_data_i;
  logic [NUM_CH*IDX_W-1:0] lut_index_o;
  logic                    valid_o;
  logic [NUM_CH-1:0]       wrap_o;

  modport master (
    output valid_i, sync_i, cfg_we_i, cfg_sel_i, cfg_ch_i, cfg_data_i,
    input  lut_index_o, valid_o, wrap_o
  );

  modport slave (
    input  valid_i, sync_i, cfg_we_i, cfg_sel_i, cfg_ch_i, cfg_data_i,
    output lut_index_o, valid_o, wrap_o
  );
endinterface

// File: rtl/nco_phase_accu_mc.sv
// Multi-channel NCO phase accumulator: NUM_CH modulo-2^ACC_W accumulators
// stepped by a shared strobe, each with programmable FCW and phase offset.
module nco_phase_accu_mc #(
  parameter int ACC_W  = 32,
  parameter int IDX_W  = 10,
  parameter int NUM_CH = 4,
  parameter int CH_W   = 4
) (
  input logic              clk,
  input logic              rst,
  nco_phase_accu_mc_if.slave bus
);

  logic [ACC_W-1:0]        acc  [NUM_CH];
  logic [ACC_W-1:0]        fcw  [NUM_CH];
  logic [ACC_W-1:0]        poff [NUM_CH];
  logic [ACC_W:0]          sum  [NUM_CH];
  logic [ACC_W-1:0]        ph   [NUM_CH];
  logic                    valid_r;
  logic                    valid_q;
  logic [NUM_CH*IDX_W-1:0] lut_q;
  logic [NUM_CH-1:0]       wrap_q;
  logic                    cfg_hit;

  // sum carries the overflow bit used for the wrap flag
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      sum[c] = {1'b0, acc[c]} + {1'b0, fcw[c]};
      ph[c]  = acc[c] + poff[c];
    end
  end

  assign cfg_hit = bus.cfg_we_i && ({1'b0, bus.cfg_ch_i} < (CH_W+1)'(NUM_CH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_r <= 1'b0;
    else     valid_r <= bus.valid_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      lut_q   <= '0;
      wrap_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c]  <= '0;
        fcw[c]  <= '0;
        poff[c] <= '0;
      end
    end else begin
      valid_q <= valid_r;
      for (int c = 0; c < NUM_CH; c++) begin
        // index uses the pre-update accumulator, so a sync still emits the old phase
        lut_q[c*IDX_W +: IDX_W] <= ph[c][ACC_W-1 -: IDX_W];
        wrap_q[c]               <= valid_r & sum[c][ACC_W];
        if (bus.sync_i)   acc[c] <= '0;
        else if (valid_r) acc[c] <= sum[c][ACC_W-1:0];
        if (cfg_hit && (bus.cfg_ch_i == CH_W'(c))) begin
          if (bus.cfg_sel_i) poff[c] <= bus.cfg_data_i;
          else               fcw[c]  <= bus.cfg_data_i;
        end
      end
    end
  end

  assign bus.lut_index_o = lut_q;
  assign bus.valid_o     = valid_q;
  assign bus.wrap_o      = wrap_q;

endmodule
